// File: rtl/axi_lite_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_sram_slave
//  Purpose  : Word-organised on-chip SRAM behind an AXI4-Lite-style slave
//             port. Reads and writes are serviced one at a time by a small
//             FSM. Every output is registered, and the number of read wait
//             states can be set by a parameter.
//  Revision : 1.0 - initial release
// ============================================================================
module axi_lite_sram_slave #(
    parameter int    ADDR_WIDTH  = 10,
    parameter int    WAIT_CYCLES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic        clock,
    input  logic        reset,
    // read address channel
    input  logic        ARvalid,
    output logic        ARready,
    input  logic [31:0] ARdata,
    input  logic [2:0]  arprot,
    // read data channel
    output logic        Rvalid,
    input  logic        Rready,
    output logic [31:0] Rdata,
    // write address channel
    input  logic        AWvalid,
    output logic        AWready,
    input  logic [31:0] AWdata,
    input  logic [2:0]  awprot,
    // write data channel
    input  logic        Wvalid,
    output logic        Wready,
    input  logic [31:0] Wdata,
    input  logic [3:0]  Wstrb,
    // write response channel
    output logic        Bvalid,
    input  logic        Bready,
    // out-of-range indication
    output logic        err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Terminal value of the wait counter. It is unused when WAIT_CYCLES is 0.
    localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_ACC  = 3'd1;
    localparam logic [2:0] RD_WAIT = 3'd2;
    localparam logic [2:0] RD_RESP = 3'd3;
    localparam logic [2:0] WR_ACC  = 3'd4;
    localparam logic [2:0] WR_RESP = 3'd5;

    logic [31:0]           mem [DEPTH];
    logic [2:0]            state;
    logic [3:0]            wait_cnt;
    logic                  rd_oor;        // out-of-range flag of the pending read
    logic [2:0]            ar_prot_q;
    logic [2:0]            aw_prot_q;

    logic [ADDR_WIDTH-1:0] rd_index;
    logic [ADDR_WIDTH-1:0] wr_index;
    logic                  rd_out_of_range;
    logic                  wr_out_of_range;

    // Byte-offset bits are ignored because alignment is checked upstream.
    // Any set bit above the word index means the address is out of range.
    assign rd_index        = ARdata[ADDR_WIDTH+1:2];
    assign wr_index        = AWdata[ADDR_WIDTH+1:2];
    assign rd_out_of_range = |ARdata[31:ADDR_WIDTH+2];
    assign wr_out_of_range = |AWdata[31:ADDR_WIDTH+2];

    // The protection fields are captured but have no effect on behaviour.
    logic unused_ok;
    assign unused_ok = ^{ARdata[1:0], AWdata[1:0], ar_prot_q, aw_prot_q};

    // Array write port. The write is committed on the edge that closes the
    // AWready/Wready cycle. A later reset therefore cannot undo it, and a
    // reset during that cycle drops the write entirely.
    always_ff @(posedge clock) begin
        if (!reset && state == WR_ACC && !wr_out_of_range) begin
            for (int i = 0; i < 4; i++) begin
                if (Wstrb[i]) begin
                    mem[wr_index][8*i +: 8] <= Wdata[8*i +: 8];
                end
            end
        end
    end

    // Transaction FSM and all registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ARready   <= 1'b0;
            AWready   <= 1'b0;
            Wready    <= 1'b0;
            Rvalid    <= 1'b0;
            Bvalid    <= 1'b0;
            err       <= 1'b0;
            Rdata     <= 32'h0;
            wait_cnt  <= 4'd0;
            rd_oor    <= 1'b0;
            ar_prot_q <= 3'd0;
            aw_prot_q <= 3'd0;
        end else begin
            // err only pulses on the first response cycle.
            err <= 1'b0;
            case (state)
                IDLE: begin
                    // Read wins when both requests are present.
                    if (ARvalid) begin
                        ARready <= 1'b1;
                        state   <= RD_ACC;
                    end else if (AWvalid && Wvalid) begin
                        AWready <= 1'b1;
                        Wready  <= 1'b1;
                        state   <= WR_ACC;
                    end
                end

                RD_ACC: begin
                    // The address is taken on this edge even if ARvalid has
                    // already dropped. Rdata is loaded here and then held
                    // until the response handshake.
                    ARready   <= 1'b0;
                    ar_prot_q <= arprot;
                    rd_oor    <= rd_out_of_range;
                    Rdata     <= rd_out_of_range ? 32'h0 : mem[rd_index];
                    wait_cnt  <= 4'd0;
                    if (WAIT_CYCLES > 0) begin
                        state <= RD_WAIT;
                    end else begin
                        Rvalid <= 1'b1;
                        err    <= rd_out_of_range;
                        state  <= RD_RESP;
                    end
                end

                RD_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        Rvalid <= 1'b1;
                        err    <= rd_oor;
                        state  <= RD_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end

                RD_RESP: begin
                    if (Rready) begin
                        Rvalid <= 1'b0;
                        state  <= IDLE;
                    end
                end

                WR_ACC: begin
                    AWready   <= 1'b0;
                    Wready    <= 1'b0;
                    aw_prot_q <= awprot;
                    Bvalid    <= 1'b1;
                    err       <= wr_out_of_range;
                    state     <= WR_RESP;
                end

                WR_RESP: begin
                    if (Bready) begin
                        Bvalid <= 1'b0;
                        state  <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_lite_sram_slave
//  Purpose  : Self-checking bench for axi_lite_sram_slave. One instance has
//             zero wait states and one has three. Both share the write
//             channel, so their memories stay identical.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_sram_slave;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] ARdata, AWdata, Wdata;
    logic [3:0]  Wstrb;
    logic        AWvalid, Wvalid, Bready;
    logic [2:0]  arprot, awprot;

    logic        ARvalid0, Rready0, ARready0, Rvalid0, AWready0, Wready0, Bvalid0, err0;
    logic [31:0] Rdata0;
    logic        ARvalid3, Rready3, ARready3, Rvalid3, AWready3, Wready3, Bvalid3, err3;
    logic [31:0] Rdata3;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        bit          exp_err;
        int          hold;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        bit          err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    always #5 clock = ~clock;

    axi_lite_sram_slave #(.ADDR_WIDTH(10), .WAIT_CYCLES(0), .INIT_FILE("")) dut0 (
        .clock(clock), .reset(reset),
        .ARvalid(ARvalid0), .ARready(ARready0), .ARdata(ARdata), .arprot(arprot),
        .Rvalid(Rvalid0), .Rready(Rready0), .Rdata(Rdata0),
        .AWvalid(AWvalid), .AWready(AWready0), .AWdata(AWdata), .awprot(awprot),
        .Wvalid(Wvalid), .Wready(Wready0), .Wdata(Wdata), .Wstrb(Wstrb),
        .Bvalid(Bvalid0), .Bready(Bready), .err(err0)
    );

    axi_lite_sram_slave #(.ADDR_WIDTH(10), .WAIT_CYCLES(3), .INIT_FILE("")) dut3 (
        .clock(clock), .reset(reset),
        .ARvalid(ARvalid3), .ARready(ARready3), .ARdata(ARdata), .arprot(arprot),
        .Rvalid(Rvalid3), .Rready(Rready3), .Rdata(Rdata3),
        .AWvalid(AWvalid), .AWready(AWready3), .AWdata(AWdata), .awprot(awprot),
        .Wvalid(Wvalid), .Wready(Wready3), .Wdata(Wdata), .Wstrb(Wstrb),
        .Bvalid(Bvalid3), .Bready(Bready), .err(err3)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic get_arready(input bit sel);
        return sel ? ARready3 : ARready0;
    endfunction
    function automatic logic get_rvalid(input bit sel);
        return sel ? Rvalid3 : Rvalid0;
    endfunction
    function automatic logic [31:0] get_rdata(input bit sel);
        return sel ? Rdata3 : Rdata0;
    endfunction
    function automatic logic get_err(input bit sel);
        return sel ? err3 : err0;
    endfunction
    task automatic set_arvalid(input bit sel, input logic v);
        if (sel) ARvalid3 = v; else ARvalid0 = v;
    endtask
    task automatic set_rready(input bit sel, input logic v);
        if (sel) Rready3 = v; else Rready0 = v;
    endtask

    task automatic all_zero(input string tag);
        check32({tag, "_ready0"}, {29'd0, ARready0, AWready0, Wready0}, 32'd0);
        check32({tag, "_valid0"}, {29'd0, Rvalid0, Bvalid0, err0}, 32'd0);
        check32({tag, "_rdata0"}, Rdata0, 32'd0);
        check32({tag, "_ready3"}, {29'd0, ARready3, AWready3, Wready3}, 32'd0);
        check32({tag, "_valid3"}, {29'd0, Rvalid3, Bvalid3, err3}, 32'd0);
        check32({tag, "_rdata3"}, Rdata3, 32'd0);
    endtask

    // Read on the selected instance. The expected response is queued when the
    // request is driven and compared when Rvalid appears.
    task automatic do_read(input bit sel, input logic [31:0] addr, input int hold,
                           input logic [31:0] exp_d, input bit exp_e);
        int   lat;
        exp_t e;
        @(posedge clock); #1;
        ARdata = addr;
        arprot = 3'b101;
        set_arvalid(sel, 1'b1);
        sb.push_back(exp_t'{exp_d, exp_e});
        @(negedge clock);
        check1("arready_early", get_arready(sel), 1'b0);
        @(posedge clock); @(negedge clock);
        check1("arready", get_arready(sel), 1'b1);
        @(posedge clock); #1;
        set_arvalid(sel, 1'b0);
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!get_rvalid(sel) && lat < 40);
        check32("r_latency", 32'(lat), sel ? 32'd4 : 32'd1);
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            check32("rdata", get_rdata(sel), e.data);
            check1("r_err", get_err(sel), e.err);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            check1("rvalid_hold", get_rvalid(sel), 1'b1);
            check32("rdata_hold", get_rdata(sel), exp_d);
            check1("err_one_cycle", get_err(sel), 1'b0);
        end
        set_rready(sel, 1'b1);
        @(posedge clock); #1;
        set_rready(sel, 1'b0);
        @(negedge clock);
        check1("rvalid_clear", get_rvalid(sel), 1'b0);
    endtask

    // Write via the shared channel; dut0 outputs are checked.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input bit exp_e);
        int   lat;
        exp_t e;
        @(posedge clock); #1;
        AWdata = addr; Wdata = data; Wstrb = strb; awprot = 3'b010;
        AWvalid = 1'b1; Wvalid = 1'b1;
        sb.push_back(exp_t'{32'h0, exp_e});
        @(negedge clock);
        check1("awready_early", AWready0, 1'b0);
        @(posedge clock); @(negedge clock);
        check32("aw_w_ready", {30'd0, AWready0, Wready0}, 32'd3);
        @(posedge clock); #1;
        AWvalid = 1'b0; Wvalid = 1'b0;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!Bvalid0 && lat < 40);
        check32("b_latency", 32'(lat), 32'd1);
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            check1("b_err", err0, e.err);
        end
        Bready = 1'b1;
        @(posedge clock); #1;
        Bready = 1'b0;
        @(negedge clock);
        check1("bvalid_clear", Bvalid0, 1'b0);
        check1("b_err_clear", err0, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        ARdata = 32'h0; AWdata = 32'h0; Wdata = 32'h0; Wstrb = 4'h0;
        AWvalid = 1'b0; Wvalid = 1'b0; Bready = 1'b0; arprot = 3'd0; awprot = 3'd0;
        ARvalid0 = 1'b0; Rready0 = 1'b0; ARvalid3 = 1'b0; Rready3 = 1'b0;

        //                 wr    addr          data          strb  exp_data      err   hold
        vecs.push_back(vec_t'{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,        1'b0, 0});
        vecs.push_back(vec_t'{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, 0});
        vecs.push_back(vec_t'{1'b1, 32'h0000_0010, 32'h5555_5555, 4'h4, 32'h0,        1'b0, 0});
        vecs.push_back(vec_t'{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDE55_BEEF, 1'b0, 2});
        vecs.push_back(vec_t'{1'b1, 32'h0000_0014, 32'h1234_5678, 4'hF, 32'h0,        1'b0, 0});
        vecs.push_back(vec_t'{1'b1, 32'h0000_0014, 32'hAABB_CCDD, 4'h0, 32'h0,        1'b0, 0});
        vecs.push_back(vec_t'{1'b0, 32'h0000_0014, 32'h0,         4'h0, 32'h1234_5678, 1'b0, 0});
        vecs.push_back(vec_t'{1'b1, 32'h0000_0014, 32'hFFFF_FFFF, 4'h9, 32'h0,        1'b0, 0});
        vecs.push_back(vec_t'{1'b0, 32'h0000_0014, 32'h0,         4'h0, 32'hFF34_56FF, 1'b0, 0});
        vecs.push_back(vec_t'{1'b0, 32'h0000_1000, 32'h0,         4'h0, 32'h0,        1'b1, 1});
        vecs.push_back(vec_t'{1'b1, 32'h0000_1010, 32'h0000_0000, 4'hF, 32'h0,        1'b1, 0});
        vecs.push_back(vec_t'{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDE55_BEEF, 1'b0, 0});
        vecs.push_back(vec_t'{1'b1, 32'h0000_0FFC, 32'h0A0B_0C0D, 4'hF, 32'h0,        1'b0, 0});
        vecs.push_back(vec_t'{1'b0, 32'h0000_0FFF, 32'h0,         4'h0, 32'h0A0B_0C0D, 1'b0, 0});
        vecs.push_back(vec_t'{1'b1, 32'h0000_0000, 32'h1111_1111, 4'hF, 32'h0,        1'b0, 0});
        vecs.push_back(vec_t'{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h1111_1111, 1'b0, 0});
        vecs.push_back(vec_t'{1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'h0,        1'b1, 0});
        vecs.push_back(vec_t'{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 32'h0A0B_0C0D, 1'b0, 1});

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        all_zero("reset");
        reset = 1'b0;
        @(negedge clock);
        all_zero("post_reset");

        // Table-driven transactions on the zero-wait instance
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr)
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_err);
            else
                do_read(1'b0, vecs[i].addr, vecs[i].hold, vecs[i].exp_data, vecs[i].exp_err);
        end

        // Three wait states, with Rready held low for five cycles
        do_read(1'b1, 32'h0000_0010, 5, 32'hDE55_BEEF, 1'b0);
        do_read(1'b1, 32'h0000_1000, 0, 32'h0, 1'b1);

        // A lone AWvalid or a lone Wvalid must not start a write
        @(posedge clock); #1;
        AWdata = 32'h30; AWvalid = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check1("aw_alone", AWready0, 1'b0);
            @(posedge clock);
        end
        #1; AWvalid = 1'b0; Wvalid = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check1("w_alone", Wready0, 1'b0);
            @(posedge clock);
        end
        #1; Wvalid = 1'b0;

        // Read and write arrive together: the read is served first, and the
        // write to the same word does not disturb the returned data
        @(posedge clock); #1;
        ARdata = 32'h10; ARvalid0 = 1'b1;
        AWdata = 32'h10; Wdata = 32'h0102_0304; Wstrb = 4'hF; AWvalid = 1'b1; Wvalid = 1'b1;
        @(posedge clock); @(negedge clock);
        check1("prio_arready", ARready0, 1'b1);
        check32("prio_no_wready", {30'd0, AWready0, Wready0}, 32'd0);
        @(posedge clock); #1;
        ARvalid0 = 1'b0;
        @(negedge clock);
        check1("prio_rvalid", Rvalid0, 1'b1);
        check32("prio_rdata", Rdata0, 32'hDE55_BEEF);
        check1("prio_aw_wait", AWready0, 1'b0);
        check1("prio_dut3_bvalid", Bvalid3, 1'b1);
        Rready0 = 1'b1;
        @(posedge clock); #1;
        Rready0 = 1'b0;
        @(negedge clock);
        check1("prio_idle_rvalid", Rvalid0, 1'b0);
        check1("prio_idle_aw", AWready0, 1'b0);
        @(posedge clock); @(negedge clock);
        check32("prio_aw_w_ready", {30'd0, AWready0, Wready0}, 32'd3);
        @(posedge clock); #1;
        AWvalid = 1'b0; Wvalid = 1'b0;
        @(negedge clock);
        check1("prio_bvalid", Bvalid0, 1'b1);
        Bready = 1'b1;
        @(posedge clock); #1;
        Bready = 1'b0;
        @(negedge clock);
        check1("prio_bclear", Bvalid0, 1'b0);
        do_read(1'b0, 32'h10, 0, 32'h0102_0304, 1'b0);
        do_read(1'b1, 32'h10, 0, 32'h0102_0304, 1'b0);

        // Reset while the three-wait instance is in RD_WAIT
        @(posedge clock); #1;
        ARdata = 32'h14; ARvalid3 = 1'b1;
        @(posedge clock); @(negedge clock);
        check1("rw_arready", ARready3, 1'b1);
        @(posedge clock); #1;
        ARvalid3 = 1'b0;
        @(posedge clock); @(negedge clock);
        reset = 1'b1;
        #1;
        all_zero("reset_rd_wait");
        @(posedge clock); @(negedge clock);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        check1("rd_abandoned", Rvalid3, 1'b0);

        // Reset while in WR_RESP: the committed write must survive
        @(posedge clock); #1;
        AWdata = 32'h20; Wdata = 32'hCAFE_F00D; Wstrb = 4'hF; AWvalid = 1'b1; Wvalid = 1'b1;
        @(posedge clock); @(negedge clock);
        check1("wr_rst_awready", AWready0, 1'b1);
        @(posedge clock); #1;
        AWvalid = 1'b0; Wvalid = 1'b0;
        @(negedge clock);
        check1("wr_rst_bvalid", Bvalid0, 1'b1);
        reset = 1'b1;
        #1;
        all_zero("reset_wr_resp");
        @(posedge clock); @(negedge clock);
        reset = 1'b0;
        do_read(1'b0, 32'h20, 0, 32'hCAFE_F00D, 1'b0);
        do_read(1'b0, 32'h10, 0, 32'h0102_0304, 1'b0);
        do_read(1'b1, 32'h20, 1, 32'hCAFE_F00D, 1'b0);

        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
